// File: rtl/mouse_ps2_tx.sv
// PS/2 device-side transmitter for a 3-byte mouse movement packet.
// The packet is built from direction flags and magnitudes at the moment of
// acceptance. Each byte goes out as an 11-bit frame with a device-driven
// clock, and there is an idle gap between the bytes of one packet.
module mouse_ps2_tx #(
  parameter int HALF = 2000,
  parameter int GAP  = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic       click,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic       arriba,
  input  logic       abajo,
  input  logic [7:0] mag_x,
  input  logic [7:0] mag_y,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done
);

  localparam int CMAX = (HALF > GAP) ? HALF : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, BIT_HI, BIT_LO, GAP_ST, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [2:0][7:0] pkt;      // pkt[0] is always the byte currently on the wire
  logic [9:0]      sh;       // frame bits still to be sent, next one at [0]

  logic [8:0]      x_new, y_new;
  logic [2:0][7:0] pkt_new;
  logic [10:0]     f_new, f_next;

  // Frame layout, index 0 first: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Build the packet from the live inputs. A zero magnitude gives 0 with
  // sign 0 even in the negative direction, because 0 - 0 = 0.
  always_comb begin
    x_new = '0;
    y_new = '0;
    if (derecha && !izquierda)      x_new = {1'b0, mag_x};
    else if (izquierda && !derecha) x_new = 9'd0 - {1'b0, mag_x};
    if (arriba && !abajo)           y_new = {1'b0, mag_y};
    else if (abajo && !arriba)      y_new = 9'd0 - {1'b0, mag_y};
    pkt_new[0] = {2'b00, y_new[8], x_new[8], 1'b1, 2'b00, click};
    pkt_new[1] = x_new[7:0];
    pkt_new[2] = y_new[7:0];
    f_new      = frame_of(pkt_new[0]);
    f_next     = frame_of(pkt[1]);
  end

  // Transmit sequencer. Every state entry reloads cnt, and all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      pkt      <= '0;
      sh       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (send) begin
            pkt      <= pkt_new;
            ps2_data <= f_new[0];
            sh       <= f_new[10:1];
            bit_cnt  <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            cnt      <= CW'(HALF - 1);
            state    <= BIT_HI;
          end
        end
        BIT_HI: begin
          if (cnt == '0) begin
            ps2_clk <= 1'b0;
            cnt     <= CW'(HALF - 1);
            state   <= BIT_LO;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BIT_LO: begin
          if (cnt == '0) begin
            ps2_clk <= 1'b1;
            if (bit_cnt != 4'd10) begin
              bit_cnt  <= bit_cnt + 4'd1;
              ps2_data <= sh[0];
              sh       <= {1'b0, sh[9:1]};
              cnt      <= CW'(HALF - 1);
              state    <= BIT_HI;
            end else if (byte_cnt != 2'd2) begin
              ps2_data <= 1'b1;
              cnt      <= CW'(GAP - 1);
              state    <= GAP_ST;
            end else begin
              ps2_data <= 1'b1;
              done     <= 1'b1;
              cnt      <= '0;
              state    <= FIN;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP_ST: begin
          if (cnt == '0) begin
            byte_cnt <= byte_cnt + 2'd1;
            pkt      <= {8'h00, pkt[2], pkt[1]};
            ps2_data <= f_next[0];
            sh       <= f_next[10:1];
            bit_cnt  <= '0;
            cnt      <= CW'(HALF - 1);
            state    <= BIT_HI;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_ps2_tx.sv
// Bench for mouse_ps2_tx. A line monitor decodes the frames and checks them
// against a queue of expected bytes.
module tb_mouse_ps2_tx;
  localparam int HALF = 2;
  localparam int GAP  = 4;
  localparam int PKT  = 33 * 2 * HALF + 2 * GAP + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic       click = 1'b0, izquierda = 1'b0, derecha = 1'b0, arriba = 1'b0, abajo = 1'b0;
  logic [7:0] mag_x = '0, mag_y = '0;
  logic       ps2_clk, ps2_data, busy, done;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int busy_len = 0;

  mouse_ps2_tx #(.HALF(HALF), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .send(send), .click(click),
    .izquierda(izquierda), .derecha(derecha), .arriba(arriba), .abajo(abajo),
    .mag_x(mag_x), .mag_y(mag_y),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: captures data on each ps2_clk fall, insists that data holds while the clock is low,
  // and checks each packet's length when done pulses.
  logic        pclk_q = 1'b1;
  logic        cap = 1'b0;
  logic [10:0] fr = '0;
  int          nb = 0;
  always @(negedge clk) begin
    if (reset) begin
      nb       = 0;
      busy_len = 0;
    end else begin
      if (busy === 1'b1) busy_len++;
      if (pclk_q === 1'b1 && ps2_clk === 1'b0) begin
        cap    = ps2_data;
        fr[nb] = ps2_data;
        nb++;
        if (nb == 11) begin
          nb = 0;
          chk("start_bit", fr[0], 1'b0);
          chk("stop_bit", fr[10], 1'b1);
          chk("parity", fr[9], ~^fr[8:1]);
          chk("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("byte", fr[8:1], exp_q.pop_front());
        end
      end else if (ps2_clk === 1'b0) begin
        chk("data_stable_low", ps2_data, cap);
      end
      if (done === 1'b1) begin
        done_cnt++;
        chk("pkt_len", busy_len, PKT);
        chk("fin_lines", {ps2_clk, ps2_data}, 2'b11);
        busy_len = 0;
      end
    end
    pclk_q = ps2_clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  // Drive inputs and pulse send in the current cycle, queueing the expected bytes.
  task automatic send_pkt(input logic c, input logic l, input logic r, input logic u, input logic d,
                          input logic [7:0] mx, input logic [7:0] my,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    click = c; izquierda = l; derecha = r; arriba = u; abajo = d;
    mag_x = mx; mag_y = my;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    send = 1'b1;
    tick();
    send = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_start", {ps2_clk, ps2_data}, 2'b10);
  endtask

  initial begin
    int d0;
    int n;
    // Reset state
    repeat (3) tick();
    chk("reset_lines", {ps2_clk, ps2_data, busy, done}, 4'b1100);
    reset = 1'b0;
    tick();

    // Right/up with click
    send_pkt(1, 0, 1, 1, 0, 8'd5, 8'd3, 8'h09, 8'h05, 8'h03);
    wait_done("done_sc1");

    // Left/down, max x, plus an ignored re-send mid-packet with changed inputs
    repeat (4) tick();
    d0 = done_cnt;
    send_pkt(0, 1, 0, 0, 1, 8'd255, 8'd1, 8'h38, 8'h01, 8'hFF);
    repeat (20) tick();
    click = 1'b1; izquierda = 1'b0; derecha = 1'b1; mag_x = 8'd7; mag_y = 8'd9;
    send = 1'b1;
    tick();
    send = 1'b0;
    chk("busy_during_resend", busy, 1'b1);
    wait_done("done_sc2");
    repeat (30) tick();
    chk("no_second_pkt", done_cnt, d0 + 1);
    chk("idle_after_ignored", busy, 1'b0);
    chk("queue_drained_sc2", exp_q.size(), 0);

    // Opposing directions cancel, then an immediate back-to-back packet
    send_pkt(0, 1, 1, 0, 0, 8'd77, 8'd44, 8'h08, 8'h00, 8'h00);
    wait_done("done_sc3");
    tick();
    chk("idle_one_cycle", busy, 1'b0);
    send_pkt(1, 0, 1, 1, 0, 8'd5, 8'd3, 8'h09, 8'h05, 8'h03);
    wait_done("done_b2b");

    // Reset during the third bit of byte1
    repeat (3) tick();
    d0 = done_cnt;
    send_pkt(0, 1, 0, 0, 1, 8'd255, 8'd1, 8'h38, 8'h01, 8'hFF);
    n = 0;
    while (busy_len < 57 && n < 500) begin
      tick();
      n++;
    end
    chk("reached_byte1", busy_len >= 57, 1);
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("abort_lines", {ps2_clk, ps2_data, busy, done}, 4'b1100);
    reset = 1'b0;
    repeat (200) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", busy, 1'b0);

    // Reset wins over a simultaneous send
    reset = 1'b1;
    send = 1'b1;
    tick();
    reset = 1'b0;
    send = 1'b0;
    tick();
    chk("reset_beats_send", busy, 1'b0);

    // Clean packet after abort
    send_pkt(0, 1, 0, 0, 1, 8'd255, 8'd1, 8'h38, 8'h01, 8'hFF);
    wait_done("done_after_abort");
    repeat (5) tick();
    chk("queue_drained_end", exp_q.size(), 0);
    chk("total_done", done_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
